// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline stage registers.
// Stage actions are decoded once per cycle and drive both datapath and perf counters.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

    localparam int unsigned EXC_W    = 5;
    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    localparam int unsigned STALL_BUBBLE = 0;
    localparam int unsigned STALL_HOLD   = 1;

    typedef enum logic [2:0] {
        ActLoad,
        ActReq,
        ActFlush,
        ActBubble,
        ActHold
    } stage_act_e;

    // Low bit index of payload lane `lane` when lanes are `width` bits wide.
    function automatic int unsigned lane_lo(int unsigned lane, int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter, cleared only by the asynchronous reset.
module pipe_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (PC, BD, exception, dest reg, payload lanes).
// Optional PIPE_PERF_CNT_EN adds bubble_cnt / flush_cnt performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned LANE_W     = 32,
    parameter int unsigned STALL_MODE = STALL_BUBBLE,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req,
    input  logic                        flush,
    input  logic                        stall,
    input  logic                        in_valid,
    input  logic [31:0]                 in_pc,
    input  logic                        in_bd,
    input  logic [EXC_W-1:0]            in_exc,
    input  logic [4:0]                  in_a3,
    input  logic [NUM_LANES*LANE_W-1:0] in_data,
    output logic                        out_valid,
    output logic [31:0]                 out_pc,
    output logic                        out_bd,
    output logic [EXC_W-1:0]            out_exc,
    output logic [4:0]                  out_a3,
    output logic [NUM_LANES*LANE_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]                 bubble_cnt,
    output logic [31:0]                 flush_cnt
`endif
);

    localparam int unsigned DATA_W = NUM_LANES * LANE_W;

    stage_act_e act;

    logic              valid_q, valid_d;
    logic [31:0]       pc_q,    pc_d;
    logic              bd_q,    bd_d;
    logic [EXC_W-1:0]  exc_q,   exc_d;
    logic [4:0]        a3_q,    a3_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        act = ActLoad;
        if (req) begin
            act = ActReq;
        end else if (flush) begin
            act = ActFlush;
        end else if (stall) begin
            act = (STALL_MODE == STALL_HOLD) ? ActHold : ActBubble;
        end
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        a3_d    = a3_q;
        data_d  = data_q;
        unique case (act)
            ActReq: begin
                valid_d = 1'b0;
                pc_d    = HANDLER_PC;
                bd_d    = 1'b0;
                exc_d   = EXC_NONE;
                a3_d    = REG_ZERO;
                data_d  = '0;
            end
            ActFlush: begin
                valid_d = 1'b0;
                pc_d    = in_pc;
                bd_d    = 1'b0;
                exc_d   = EXC_NONE;
                a3_d    = REG_ZERO;
                data_d  = '0;
            end
            ActBubble: begin
                // PC/BD survive the bubble so CP0 can still report a macro-PC.
                valid_d = 1'b0;
                pc_d    = in_pc;
                bd_d    = in_bd;
                exc_d   = EXC_NONE;
                a3_d    = REG_ZERO;
                data_d  = '0;
            end
            ActHold: begin
            end
            ActLoad: begin
                valid_d = in_valid;
                pc_d    = in_pc;
                bd_d    = in_bd;
                exc_d   = in_valid ? in_exc : EXC_NONE;
                a3_d    = in_valid ? in_a3  : REG_ZERO;
                for (int unsigned k = 0; k < NUM_LANES; k++) begin
                    data_d[lane_lo(k, LANE_W) +: LANE_W] = in_data[lane_lo(k, LANE_W) +: LANE_W];
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            bd_q    <= 1'b0;
            exc_q   <= EXC_NONE;
            a3_q    <= REG_ZERO;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            a3_q    <= a3_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_bd    = bd_q;
    assign out_exc   = exc_q;
    assign out_a3    = a3_q;
    assign out_data  = data_q;

`ifdef PIPE_PERF_CNT_EN
    logic bubble_inc;
    logic flush_inc;

    assign bubble_inc = (act == ActBubble) || (act == ActHold);
    assign flush_inc  = (act == ActReq) || (act == ActFlush);

    pipe_perf_cnt #(
        .W (32)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    pipe_perf_cnt #(
        .W (32)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`else
    // Counter-free build: datapath above is the complete stage.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one bubble-mode and one hold-mode instance on shared inputs.
// Counter checks are active when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_reg;

    localparam int DW = 64;

    typedef struct packed {
        logic          valid;
        logic [31:0]   pc;
        logic          bd;
        logic [4:0]    exc;
        logic [4:0]    a3;
        logic [DW-1:0] data;
    } st_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, req, flush, stall, in_valid, in_bd;
    logic [31:0]   in_pc;
    logic [4:0]    in_exc, in_a3;
    logic [DW-1:0] in_data;

    logic          o0_valid, o0_bd, o1_valid, o1_bd;
    logic [31:0]   o0_pc, o1_pc;
    logic [4:0]    o0_exc, o0_a3, o1_exc, o1_a3;
    logic [DW-1:0] o0_data, o1_data;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]   b0, f0, b1, f1;
`endif

    pipe_stage_reg #(.NUM_LANES(2), .LANE_W(32), .STALL_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
        .in_a3(in_a3), .in_data(in_data),
        .out_valid(o0_valid), .out_pc(o0_pc), .out_bd(o0_bd), .out_exc(o0_exc),
        .out_a3(o0_a3), .out_data(o0_data)
`ifdef PIPE_PERF_CNT_EN
        , .bubble_cnt(b0), .flush_cnt(f0)
`endif
    );

    pipe_stage_reg #(.NUM_LANES(2), .LANE_W(32), .STALL_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
        .in_a3(in_a3), .in_data(in_data),
        .out_valid(o1_valid), .out_pc(o1_pc), .out_bd(o1_bd), .out_exc(o1_exc),
        .out_a3(o1_a3), .out_data(o1_data)
`ifdef PIPE_PERF_CNT_EN
        , .bubble_cnt(b1), .flush_cnt(f1)
`endif
    );

    int total = 0;
    int bad   = 0;
    st_t e0, e1;
    logic [31:0] c_bub, c_fl;

    function automatic st_t rst_st();
        st_t s;
        s.valid = 1'b0; s.pc = 32'h0000_3000; s.bd = 1'b0;
        s.exc = 5'd0; s.a3 = 5'd0; s.data = '0;
        return s;
    endfunction

    // Reference: what the stage should hold after the next edge, from the rule list.
    function automatic st_t nxt(bit hold_mode, st_t cur);
        st_t n;
        n = cur;
        if (req) begin
            n = rst_st();
            n.pc = 32'h0000_4180;
        end else if (flush) begin
            n = rst_st();
            n.pc = in_pc;
        end else if (stall) begin
            if (!hold_mode) begin
                n = rst_st();
                n.pc = in_pc;
                n.bd = in_bd;
            end
        end else begin
            n.valid = in_valid;
            n.pc    = in_pc;
            n.bd    = in_bd;
            n.exc   = in_valid ? in_exc : 5'd0;
            n.a3    = in_valid ? in_a3  : 5'd0;
            n.data  = in_data;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic check_both(input string tag);
        chk({tag, ".valid0"}, 64'(o0_valid), 64'(e0.valid));
        chk({tag, ".pc0"},    64'(o0_pc),    64'(e0.pc));
        chk({tag, ".bd0"},    64'(o0_bd),    64'(e0.bd));
        chk({tag, ".exc0"},   64'(o0_exc),   64'(e0.exc));
        chk({tag, ".a30"},    64'(o0_a3),    64'(e0.a3));
        chk({tag, ".data0"},  o0_data,       e0.data);
        chk({tag, ".valid1"}, 64'(o1_valid), 64'(e1.valid));
        chk({tag, ".pc1"},    64'(o1_pc),    64'(e1.pc));
        chk({tag, ".bd1"},    64'(o1_bd),    64'(e1.bd));
        chk({tag, ".exc1"},   64'(o1_exc),   64'(e1.exc));
        chk({tag, ".a31"},    64'(o1_a3),    64'(e1.a3));
        chk({tag, ".data1"},  o1_data,       e1.data);
`ifdef PIPE_PERF_CNT_EN
        chk({tag, ".bub0"}, 64'(b0), 64'(c_bub));
        chk({tag, ".fl0"},  64'(f0), 64'(c_fl));
        chk({tag, ".bub1"}, 64'(b1), 64'(c_bub));
        chk({tag, ".fl1"},  64'(f1), 64'(c_fl));
`endif
    endtask

    task automatic cycle(input string tag);
        e0 = nxt(1'b0, e0);
        e1 = nxt(1'b1, e1);
        if (req || flush) begin
            if (c_fl != 32'hFFFF_FFFF) c_fl++;
        end else if (stall) begin
            if (c_bub != 32'hFFFF_FFFF) c_bub++;
        end
        @(posedge clk);
        #1;
        check_both(tag);
    endtask

    // Called just after an edge; reset must act before the next edge.
    task automatic pulse_reset(input string tag);
        #1 reset = 1'b1;
        #1;
        e0 = rst_st(); e1 = rst_st(); c_bub = '0; c_fl = '0;
        check_both(tag);
        reset = 1'b0;
    endtask

    task automatic idle_inputs();
        req = 0; flush = 0; stall = 0; in_valid = 0; in_bd = 0;
        in_pc = 32'h0000_3000; in_exc = 0; in_a3 = 0; in_data = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        e0 = rst_st(); e1 = rst_st(); c_bub = '0; c_fl = '0;
        #2;
        check_both("reset_async");
        @(posedge clk);
        #1;
        check_both("reset_held");
        reset = 1'b0;

        // 1: idle load after reset keeps the reset PC, nothing valid
        cycle("t1_idle");
        chk("t1_pc", 64'(o0_pc), 64'h3000);

        // 2: real instruction passes through unchanged
        in_valid = 1; in_pc = 32'h0000_3004; in_a3 = 5'd8;
        in_data = {32'hCAFE_0001, 32'h1234_5678};
        cycle("t2_load");
        chk("t2_valid", 64'(o0_valid), 64'd1);
        chk("t2_a3", 64'(o0_a3), 64'd8);
        chk("t2_lane0", 64'(o0_data[31:0]), 64'h1234_5678);

        // 3: stall -> bubble on dut0, hold on dut1
        stall = 1; in_pc = 32'h0000_3010; in_bd = 1; in_data = '1; in_a3 = 5'd9;
        cycle("t3_stall");
        chk("t3_b_pc", 64'(o0_pc), 64'h3010);
        chk("t3_b_bd", 64'(o0_bd), 64'd1);
        chk("t3_b_data", o0_data, 64'd0);
        chk("t3_h_pc", 64'(o1_pc), 64'h3004);
        chk("t3_h_a3", 64'(o1_a3), 64'd8);

        // 4: req beats stall and flush; then flush alone
        req = 1; flush = 1;
        cycle("t4_req");
        chk("t4_pc", 64'(o1_pc), 64'h4180);
        req = 0; stall = 0; in_pc = 32'h0000_3020;
        cycle("t4_flush");
        chk("t4_fpc", 64'(o0_pc), 64'h3020);

        // 5: a load bubble never carries a3/exc
        flush = 0; in_valid = 0; in_a3 = 5'd31; in_exc = 5'd4; in_pc = 32'h0000_3030;
        cycle("t5_bubble_load");
        chk("t5_a3", 64'(o1_a3), 64'd0);
        chk("t5_exc", 64'(o1_exc), 64'd0);

        // 6: counter sequence 3 stalls, 2 flushes, 1 req, then async reset
        idle_inputs();
        pulse_reset("t6_clr");
        stall = 1;
        repeat (3) cycle("t6_stall");
        stall = 0; flush = 1;
        repeat (2) cycle("t6_flush");
        flush = 0; req = 1;
        cycle("t6_req");
        req = 0; stall = 1;
`ifdef PIPE_PERF_CNT_EN
        chk("t6_bub", 64'(b0), 64'd3);
        chk("t6_fl", 64'(f1), 64'd3);
`endif
        pulse_reset("t6_async");

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            req      = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 6) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            in_valid = 1'($urandom);
            in_bd    = 1'($urandom);
            in_pc    = $urandom;
            in_exc   = 5'($urandom);
            in_a3    = 5'($urandom);
            in_data  = {$urandom, $urandom};
            if (i % 67 == 66) begin
                pulse_reset("rnd_reset");
            end else begin
                cycle("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
